// File: rtl/counter_stim_gen_pkg.sv
// Shared types and constants for the counter stimulus generator.
// Holds the FSM and op encodings, the LFSR tap mask and its step function.
package counter_stim_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_INC  = 2'b01,
        OP_LD   = 2'b10,
        OP_INC2 = 2'b11
    } op_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/counter_stim_gen_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and a shift enable.
module counter_stim_gen_lfsr16
    import counter_stim_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/counter_stim_gen.sv
// Legal-traffic generator and scoreboard for a loadable up-counter: issues ld/inc
// under LFSR control, tracks the expected count and flags data_out disagreements.
module counter_stim_gen
    import counter_stim_gen_pkg::*;
#(
    parameter int          WIDTH     = 3,
    parameter int          NUM_OPS   = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inject_err,
    input  logic [WIDTH-1:0] data_out,
    output logic             ld,
    output logic             inc,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_count,
    output logic [7:0]       op_count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [7:0]       LAST_OP   = 8'(NUM_OPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      lfsr;
    logic             lfsr_en;
    logic             lfsr_rst;
    logic [WIDTH-1:0] exp_cnt;
    logic [WIDTH-1:0] exp_nxt;
    logic             ld_dec;
    logic             inc_dec;
    logic             inject_hit;
    logic             cmp_armed;
    logic             cmp_fail;

    // The op decided this cycle is presented next cycle, so shift only when heading into RUN.
    assign lfsr_en  = (state_nxt == ST_RUN);
    // All-zero is the lock-up state of the LFSR; reload the seed should it ever get there.
    assign lfsr_rst = rst || (lfsr == '0);

    counter_stim_gen_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (lfsr_rst),
        .en   (lfsr_en),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if ((ld || inc) && op_count == LAST_OP) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
    end

    // Count the counter holds once the op now on ld/inc has been applied (ld wins).
    assign exp_nxt    = ld ? data_in : (inc ? exp_cnt + WIDTH'(1) : exp_cnt);
    assign inject_hit = inject_err && (lfsr[15:14] == 2'b11);

    // exp_nxt is what the counter shows when the op decided here reaches it.
    always_comb begin
        ld_dec  = 1'b0;
        inc_dec = 1'b0;
        if (inject_hit) begin
            if (exp_nxt == MAX_COUNT) begin
                inc_dec = 1'b1;
            end else begin
                ld_dec  = 1'b1;
                inc_dec = 1'b1;
            end
        end else begin
            case (op_t'(lfsr[1:0]))
                OP_LD:           ld_dec = 1'b1;
                OP_INC, OP_INC2: if (exp_nxt == MAX_COUNT) ld_dec = 1'b1;
                                 else inc_dec = 1'b1;
                default: ;
            endcase
        end
    end

    assign cmp_fail = cmp_armed && (data_out != exp_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            ld        <= 1'b0;
            inc       <= 1'b0;
            data_in   <= '0;
            exp_cnt   <= '0;
            cmp_armed <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            op_count  <= '0;
        end else begin
            ld        <= lfsr_en && ld_dec;
            inc       <= lfsr_en && inc_dec;
            if (lfsr_en) begin
                data_in <= lfsr[WIDTH+1:2];
            end
            exp_cnt   <= exp_nxt;
            // The first RUN cycle is not compared; every later RUN cycle and DRAIN are.
            cmp_armed <= (state == ST_RUN);
            mismatch  <= cmp_fail;
            if (state == ST_IDLE && start) begin
                op_count  <= '0;
                err_count <= '0;
            end else begin
                if (state == ST_RUN && (ld || inc)) begin
                    op_count <= op_count + 8'd1;
                end
                if (cmp_fail && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_stim_gen.sv
// Self-checking bench for counter_stim_gen: an ideal 3-bit counter closes the loop and a
// transaction-level reference predicts every issued op, mismatch pulse and final count.
module tb_counter_stim_gen;

    localparam int               WIDTH     = 3;
    localparam int               NUM_OPS   = 64;
    localparam int               SAT_OPS   = 255;
    localparam logic [15:0]      SEED      = 16'hACE1;
    localparam logic [WIDTH-1:0] MAXV      = 3'd7;
    localparam logic [WIDTH-1:0] STUCK_VAL = 3'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             start_sat = 1'b0;
    logic             inject_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] cnt;
    logic             ld, inc, busy, done, mismatch;
    logic [WIDTH-1:0] data_in;
    logic [7:0]       err_count, op_count;
    logic             ld_s, inc_s, busy_s, done_s, mismatch_s;
    logic [WIDTH-1:0] data_in_s;
    logic [7:0]       err_count_s, op_count_s;
    bit               stuck = 1'b0;

    int checks = 0;
    int failures = 0;
    int viol_ovf = 0;
    int viol_ldinc = 0;

    logic [15:0]      m_lfsr = SEED;
    logic [WIDTH-1:0] m_cnt  = '0;

    always #5 clk = ~clk;

    // Ideal counter under test-bench control; optionally replaced by a stuck value.
    always @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (ld)  cnt <= data_in;
        else if (inc) cnt <= cnt + 1'b1;
    end
    assign data_out = stuck ? STUCK_VAL : cnt;

    counter_stim_gen #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .LFSR_SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .inject_err (inject_err),
        .data_out   (data_out),
        .ld         (ld),
        .inc        (inc),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch),
        .err_count  (err_count),
        .op_count   (op_count)
    );

    counter_stim_gen #(.WIDTH(WIDTH), .NUM_OPS(SAT_OPS), .LFSR_SEED(SEED)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .start      (start_sat),
        .inject_err (1'b0),
        .data_out   (STUCK_VAL),
        .ld         (ld_s),
        .inc        (inc_s),
        .data_in    (data_in_s),
        .busy       (busy_s),
        .done       (done_s),
        .mismatch   (mismatch_s),
        .err_count  (err_count_s),
        .op_count   (op_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    // Op rules: injection first, then the LFSR choice with inc-at-max turned into a load.
    function automatic void predict_op(input logic [15:0] l, input logic [WIDTH-1:0] c,
                                       input bit inj, output bit p_ld, output bit p_inc);
        p_ld  = 1'b0;
        p_inc = 1'b0;
        if (inj && l[15:14] == 2'b11) begin
            if (c == MAXV) p_inc = 1'b1;
            else begin p_ld = 1'b1; p_inc = 1'b1; end
        end else if (l[1:0] == 2'b10) begin
            p_ld = 1'b1;
        end else if (l[1:0] != 2'b00) begin
            if (c == MAXV) p_ld = 1'b1;
            else p_inc = 1'b1;
        end
    endfunction

    function automatic bit pick_inj(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Expected err_count of a fresh (post-reset) run against a counter stuck at STUCK_VAL.
    function automatic int stuck_errs_model(input int nops);
        logic [15:0]      l = SEED;
        logic [WIDTH-1:0] c = '0;
        int ops = 0;
        int errs = 0;
        bit first = 1'b1;
        bit pl, pi;
        while (ops < nops) begin
            if (!first && c != STUCK_VAL) errs++;
            predict_op(l, c, 1'b0, pl, pi);
            if (pl) c = l[WIDTH+1:2];
            else if (pi) c = c + 1'b1;
            if (pl || pi) ops++;
            l = lfsr_next(l);
            first = 1'b0;
        end
        if (c != STUCK_VAL) errs++;
        return sat8(errs);
    endfunction

    task automatic idle_gap();
        int n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            inject_err = 1'(pick_inj(2));
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 0);
        end
        inject_err = 1'b0;
    endtask

    // One run from IDLE; called at a negedge. abort_at>0 resets the block after that many ops.
    task automatic do_run(input string name, input int inj_mode, input bit stk, input int abort_at);
        bit               pl, pi, inj_now, first, exp_mis;
        logic [WIDTH-1:0] seen;
        int               m_ops, m_errs, cyc;
        stuck      = stk;
        inj_now    = pick_inj(inj_mode);
        inject_err = inj_now;
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_ops   = 0;
        m_errs  = 0;
        cyc     = 0;
        first   = 1'b1;
        exp_mis = 1'b0;
        while (m_ops < NUM_OPS) begin
            if (cyc >= 1000) begin
                check({name, "_budget"}, m_ops, NUM_OPS);
                break;
            end
            check({name, "_busy_done"}, {30'd0, busy, done}, 2);
            check({name, "_mis"}, {31'd0, mismatch}, {31'd0, exp_mis});
            seen    = stk ? STUCK_VAL : m_cnt;
            exp_mis = !first && (seen != m_cnt);
            m_errs += int'(exp_mis);
            predict_op(m_lfsr, m_cnt, inj_now, pl, pi);
            check({name, "_ld"}, {31'd0, ld}, {31'd0, pl});
            check({name, "_inc"}, {31'd0, inc}, {31'd0, pi});
            if (pl) check({name, "_din"}, {29'd0, data_in}, {29'd0, m_lfsr[WIDTH+1:2]});
            if (ld && inc) viol_ldinc++;
            if (inc && data_out == MAXV) viol_ovf++;
            if (pl) m_cnt = m_lfsr[WIDTH+1:2];
            else if (pi) m_cnt = m_cnt + 1'b1;
            if (pl || pi) m_ops++;
            m_lfsr     = lfsr_next(m_lfsr);
            inj_now    = pick_inj(inj_mode);
            inject_err = inj_now;
            start      = ($urandom_range(0, 7) == 0);
            first      = 1'b0;
            cyc++;
            if (abort_at != 0 && m_ops == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                check({name, "_rst_strobes"}, {30'd0, ld, inc}, 0);
                check({name, "_rst_busy_done"}, {30'd0, busy, done}, 0);
                check({name, "_rst_mis"}, {31'd0, mismatch}, 0);
                check({name, "_rst_counts"}, {16'd0, err_count, op_count}, 0);
                rst        = 1'b0;
                inject_err = 1'b0;
                m_lfsr     = SEED;
                m_cnt      = '0;
                return;
            end
            @(negedge clk);
        end
        // DRAIN: no strobes, last op gets compared; start here must be ignored.
        start      = 1'b1;
        inject_err = 1'b0;
        check({name, "_drain_busy_done"}, {30'd0, busy, done}, 2);
        check({name, "_drain_strobes"}, {30'd0, ld, inc}, 0);
        check({name, "_drain_mis"}, {31'd0, mismatch}, {31'd0, exp_mis});
        seen    = stk ? STUCK_VAL : m_cnt;
        exp_mis = (seen != m_cnt);
        m_errs += int'(exp_mis);
        @(negedge clk);
        check({name, "_done_busy_done"}, {30'd0, busy, done}, 1);
        check({name, "_done_mis"}, {31'd0, mismatch}, {31'd0, exp_mis});
        check({name, "_op_count"}, {24'd0, op_count}, NUM_OPS);
        check({name, "_err_count"}, {24'd0, err_count}, sat8(m_errs));
        @(negedge clk);
        start = 1'b0;
        check({name, "_idle_busy_done"}, {30'd0, busy, done}, 0);
        check({name, "_idle_mis"}, {31'd0, mismatch}, 0);
        check({name, "_hold_op_count"}, {24'd0, op_count}, NUM_OPS);
        stuck = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_exp;
        repeat (3) @(negedge clk);
        check("reset_strobes", {30'd0, ld, inc}, 0);
        check("reset_busy_done", {30'd0, busy, done}, 0);
        check("reset_mis", {31'd0, mismatch}, 0);
        check("reset_counts", {16'd0, err_count, op_count}, 0);
        check("reset_data_in", {29'd0, data_in}, 0);
        rst = 1'b0;

        do_run("legal", 0, 1'b0, 0);
        check("legal_ldinc_seen", viol_ldinc, 0);
        check("legal_ovf_seen", viol_ovf, 0);
        idle_gap();
        do_run("mixed_a", 2, 1'b0, 0);
        idle_gap();
        do_run("mixed_b", 2, 1'b0, 0);
        idle_gap();

        viol_ldinc = 0;
        viol_ovf   = 0;
        for (int r = 0; r < 4; r++) begin
            do_run("inject", 1, 1'b0, 0);
            idle_gap();
        end
        check("inject_ldinc_fired", {31'd0, viol_ldinc > 0}, 1);
        check("inject_ovf_fired", {31'd0, viol_ovf > 0}, 1);

        do_run("stuck", 0, 1'b1, 0);
        check("stuck_errs_nonzero", {31'd0, err_count != 8'd0}, 1);
        idle_gap();

        do_run("abort", 0, 1'b0, 20);
        do_run("after_abort", 0, 1'b0, 0);

        sat_exp   = stuck_errs_model(SAT_OPS);
        start_sat = 1'b1;
        @(negedge clk);
        start_sat = 1'b0;
        check("sat_busy", {31'd0, busy_s}, 1);
        for (int i = 0; i < 3000 && !done_s; i++) @(negedge clk);
        check("sat_done", {31'd0, done_s}, 1);
        check("sat_op_count", {24'd0, op_count_s}, SAT_OPS);
        check("sat_err_count", {24'd0, err_count_s}, sat_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
